// File: rtl/test_monitor_pkg.sv
// Shared types and constants for the test_monitor pass/fail and event bookkeeping block.
package test_monitor_pkg;

    localparam int STATE_W      = 2;
    localparam int FAIL_CAUSE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PASS = 2'd2,
        FAIL = 2'd3
    } mon_state_e;

    typedef enum logic [FAIL_CAUSE_W-1:0] {
        NONE     = 2'd0,
        MISMATCH = 2'd1,
        TIMEOUT  = 2'd2
    } fail_cause_e;

    function automatic logic is_final(input mon_state_e s);
        return (s == PASS) || (s == FAIL);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with sticky overflow flag; clr is a synchronous clear
// that the parent also drives from its reset.
module sat_counter
    import test_monitor_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] value,
    output logic                 ovf
);

    localparam logic [CNT_WIDTH-1:0] MAX_VAL = '1;

    // An increment arriving at full scale is lost and recorded in ovf.
    always_ff @(posedge clk) begin
        if (clr) begin
            value <= '0;
            ovf   <= 1'b0;
        end else if (inc) begin
            if (value == MAX_VAL) begin
                ovf <= 1'b1;
            end else begin
                value <= value + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/test_monitor.sv
// Run-window monitor: counts events, declares PASS/FAIL from a watched write or timeout,
// and exposes snapshotted counters. Define TEST_MONITOR_EDGE_EN for rising-edge event counting.
module test_monitor
    import test_monitor_pkg::*;
#(
    parameter int          NUM_EVENTS     = 4,
    parameter int          CNT_WIDTH      = 32,
    parameter int          ADDR_WIDTH     = 32,
    parameter int          DATA_WIDTH     = 32,
    parameter int unsigned CHECK_ADDR     = 378,
    parameter int unsigned EXPECT_DATA    = 720,
    parameter int unsigned TIMEOUT_CYCLES = 5000
) (
    input  logic                               clk,
    input  logic                               rst_BF_n,
    input  logic                               start,
    input  logic                               clear,
    input  logic [NUM_EVENTS-1:0]              event_i,
    input  logic                               mem_we,
    input  logic [ADDR_WIDTH-1:0]              mem_addr,
    input  logic [DATA_WIDTH-1:0]              mem_wdata,
    input  logic                               snap_req,
    input  logic [$clog2(NUM_EVENTS+1)-1:0]    rd_sel,
    output logic [CNT_WIDTH-1:0]               rd_data,
    output logic [NUM_EVENTS-1:0]              ovf,
    output logic [STATE_W-1:0]                 state_o,
    output logic                               done,
    output logic                               pass,
    output logic [FAIL_CAUSE_W-1:0]            fail_cause
);

    localparam int                    SEL_W    = $clog2(NUM_EVENTS + 1);
    localparam logic [DATA_WIDTH-1:0] EXP_WORD = DATA_WIDTH'(EXPECT_DATA);
    localparam logic [63:0]           TO_LAST  = 64'(TIMEOUT_CYCLES) - 64'd1;

    mon_state_e  state, state_nxt;
    fail_cause_e cause, cause_nxt;

    logic                 start_run;
    logic                 counting;
    logic                 cnt_clr;
    logic                 addr_hit;
    logic                 data_ok;
    logic                 timeout_hit;
    logic [CNT_WIDTH-1:0] cycle_cnt;
    logic [NUM_EVENTS-1:0] inc;
    logic [CNT_WIDTH-1:0] ev_cnt [NUM_EVENTS];
    logic [CNT_WIDTH-1:0] shadow [NUM_EVENTS+1];

    assign start_run = (state == IDLE) && start && !clear;
    assign counting  = (state == RUN) && !clear;
    assign cnt_clr   = !rst_BF_n || clear || start_run;

    // Comparisons are zero-extended so an unrepresentable address or timeout never fires.
    assign addr_hit    = mem_we && (64'(mem_addr) == 64'(CHECK_ADDR));
    assign data_ok     = (mem_wdata == EXP_WORD);
    assign timeout_hit = (64'(cycle_cnt) == TO_LAST);

    always_comb begin
        state_nxt = state;
        cause_nxt = cause;
        if (clear) begin
            state_nxt = IDLE;
            cause_nxt = NONE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) state_nxt = RUN;
                end
                RUN: begin
                    if (addr_hit) begin
                        if (data_ok) begin
                            state_nxt = PASS;
                        end else begin
                            state_nxt = FAIL;
                            cause_nxt = MISMATCH;
                        end
                    end else if (timeout_hit) begin
                        state_nxt = FAIL;
                        cause_nxt = TIMEOUT;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_BF_n) begin
            state <= IDLE;
            cause <= NONE;
            done  <= 1'b0;
            pass  <= 1'b0;
        end else begin
            state <= state_nxt;
            cause <= cause_nxt;
            done  <= is_final(state_nxt);
            pass  <= (state_nxt == PASS);
        end
    end

    assign state_o    = state;
    assign fail_cause = cause;

    // The cycle counter wraps rather than saturates; the timeout bounds it in normal use.
    always_ff @(posedge clk) begin
        if (cnt_clr) begin
            cycle_cnt <= '0;
        end else if (counting) begin
            cycle_cnt <= cycle_cnt + CNT_WIDTH'(1);
        end
    end

`ifdef TEST_MONITOR_EDGE_EN
    logic [NUM_EVENTS-1:0] ev_prev;

    always_ff @(posedge clk) begin
        if (cnt_clr) begin
            ev_prev <= '0;
        end else begin
            ev_prev <= event_i;
        end
    end

    assign inc = counting ? (event_i & ~ev_prev) : '0;
`else
    assign inc = counting ? event_i : '0;
`endif

    for (genvar g = 0; g < NUM_EVENTS; g++) begin : g_evcnt
        sat_counter #(
            .CNT_WIDTH(CNT_WIDTH)
        ) u_cnt (
            .clk  (clk),
            .clr  (cnt_clr),
            .inc  (inc[g]),
            .value(ev_cnt[g]),
            .ovf  (ovf[g])
        );
    end

    // Shadows capture the pre-increment live values and survive clear.
    always_ff @(posedge clk) begin
        if (!rst_BF_n) begin
            for (int i = 0; i <= NUM_EVENTS; i++) shadow[i] <= '0;
        end else if (snap_req) begin
            for (int i = 0; i < NUM_EVENTS; i++) shadow[i] <= ev_cnt[i];
            shadow[NUM_EVENTS] <= cycle_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_BF_n) begin
            rd_data <= '0;
        end else if (rd_sel <= SEL_W'(NUM_EVENTS)) begin
            rd_data <= shadow[rd_sel];
        end else begin
            rd_data <= '0;
        end
    end

endmodule

// File: tb/tb_test_monitor.sv
// Randomized and directed bench for test_monitor with a transaction-level reference model;
// two instances cover a short-timeout build and a narrow-counter saturation build.
module tb_test_monitor;

    localparam int NE  = 4;
    localparam int WA  = 8;
    localparam int TOA = 10;
    localparam int WB  = 4;
    localparam int TOB = 1000;
    localparam int CA  = 378;
    localparam int ED  = 720;

    logic          clk = 1'b0;
    logic          rst_n, start, clear, snap, we;
    logic [NE-1:0] ev;
    logic [31:0]   addr, wdata;
    logic [2:0]    rd_sel;

    logic [WA-1:0] a_rd;
    logic [WB-1:0] b_rd;
    logic [NE-1:0] a_ovf, b_ovf;
    logic [1:0]    a_st, b_st, a_fc, b_fc;
    logic          a_done, b_done, a_pass, b_pass;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    test_monitor #(.NUM_EVENTS(NE), .CNT_WIDTH(WA), .TIMEOUT_CYCLES(TOA)) dut_a (
        .clk(clk), .rst_BF_n(rst_n), .start(start), .clear(clear), .event_i(ev),
        .mem_we(we), .mem_addr(addr), .mem_wdata(wdata), .snap_req(snap), .rd_sel(rd_sel),
        .rd_data(a_rd), .ovf(a_ovf), .state_o(a_st), .done(a_done), .pass(a_pass),
        .fail_cause(a_fc));

    test_monitor #(.NUM_EVENTS(NE), .CNT_WIDTH(WB), .TIMEOUT_CYCLES(TOB)) dut_b (
        .clk(clk), .rst_BF_n(rst_n), .start(start), .clear(clear), .event_i(ev),
        .mem_we(we), .mem_addr(addr), .mem_wdata(wdata), .snap_req(snap), .rd_sel(rd_sel),
        .rd_data(b_rd), .ovf(b_ovf), .state_o(b_st), .done(b_done), .pass(b_pass),
        .fail_cause(b_fc));

    // Reference model state: st 0 idle, 1 run, 2 pass, 3 fail; live[NE] is the cycle count.
    typedef struct packed {
        logic [1:0]         st;
        logic [1:0]         cause;
        logic [NE:0][31:0]  live;
        logic [NE:0][31:0]  shadow;
        logic [NE-1:0]      ovf;
        logic [NE-1:0]      prev;
        logic [31:0]        rd;
    } mdl_t;

    mdl_t ma, mb;

    function automatic mdl_t step(input mdl_t m, input int w, input int to, input logic rn,
                                  input logic st, input logic cl, input logic [NE-1:0] e,
                                  input logic wr, input logic [31:0] ad, input logic [31:0] wd,
                                  input logic sn, input logic [2:0] rs);
        mdl_t n;
        logic [31:0] mx;
        logic hit;
        int sel;
        mx = (32'd1 << w) - 32'd1;
        n = '0;
        if (!rn) return n;
        n = m;
        sel = int'(rs);
        n.rd = (sel <= NE) ? m.shadow[sel] : 32'd0;
        if (sn) n.shadow = m.live;
        n.prev = e;
        if (cl) begin
            n.st = 0; n.cause = 0; n.live = '0; n.ovf = '0; n.prev = '0;
        end else if (m.st == 2'd0) begin
            if (st) begin
                n.st = 1; n.live = '0; n.prev = '0;
            end
        end else if (m.st == 2'd1) begin
            n.live[NE] = (m.live[NE] + 32'd1) & mx;
            for (int i = 0; i < NE; i++) begin
`ifdef TEST_MONITOR_EDGE_EN
                hit = e[i] && !m.prev[i];
`else
                hit = e[i];
`endif
                if (hit) begin
                    if (m.live[i] == mx) n.ovf[i] = 1'b1;
                    else n.live[i] = m.live[i] + 32'd1;
                end
            end
            if (wr && ad == 32'(CA)) begin
                n.st    = (wd == 32'(ED)) ? 2'd2 : 2'd3;
                n.cause = (wd == 32'(ED)) ? 2'd0 : 2'd1;
            end else if (m.live[NE] == 32'(to - 1)) begin
                n.st = 3; n.cause = 2;
            end
        end
        return n;
    endfunction

    always @(posedge clk) begin
        ma <= step(ma, WA, TOA, rst_n, start, clear, ev, we, addr, wdata, snap, rd_sel);
        mb <= step(mb, WB, TOB, rst_n, start, clear, ev, we, addr, wdata, snap, rd_sel);
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_dut(input string tag, input mdl_t m, input logic [1:0] st,
                           input logic dn, input logic ps, input logic [1:0] fc,
                           input logic [NE-1:0] ov, input logic [31:0] rd);
        chk({tag, "_state"}, st, m.st);
        chk({tag, "_done"}, dn, (m.st >= 2'd2));
        chk({tag, "_pass"}, ps, (m.st == 2'd2));
        chk({tag, "_cause"}, fc, m.cause);
        chk({tag, "_ovf"}, ov, m.ovf);
        chk({tag, "_rd"}, rd, m.rd);
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            cmp_dut("a", ma, a_st, a_done, a_pass, a_fc, a_ovf, 32'(a_rd));
            cmp_dut("b", mb, b_st, b_done, b_pass, b_fc, b_ovf, 32'(b_rd));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic restart();
        clear = 1'b1; tick(); clear = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic read_shadow(input logic [2:0] sel);
        snap = 1'b1; tick(); snap = 1'b0;
        rd_sel = sel; tick();
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; clear = 1'b0; snap = 1'b0; we = 1'b0;
        ev = '0; addr = '0; wdata = '0; rd_sel = '0;
        tick();
        cmp_en = 1'b1;
        tick();
        chk("reset_state", a_st, 0);
        chk("reset_done", a_done, 0);
        chk("reset_rd", a_rd, 0);
        chk("reset_cause", a_fc, 0);
        rst_n = 1'b1;

        // Pass: three event pulses then the matching write.
        start = 1'b1; tick(); start = 1'b0;
        chk("run_state", a_st, 1);
        for (int k = 0; k < 3; k++) begin
            ev = 4'b0001; tick(); ev = '0; tick();
        end
        we = 1'b1; addr = 32'(CA); wdata = 32'(ED); tick(); we = 1'b0;
        chk("pass_state", a_st, 2);
        chk("pass_done", a_done, 1);
        chk("pass_pass", a_pass, 1);
        chk("pass_cause", a_fc, 0);
        read_shadow(3'd0);
        chk("pass_ev0", a_rd, 3);
        rd_sel = 3'd4; tick();
        chk("pass_cycles", a_rd, 7);

        // Mismatch, then a later correct write must not rescue the run.
        restart();
        we = 1'b1; addr = 32'(CA); wdata = 32'(ED - 1); tick();
        chk("mis_state", a_st, 3);
        chk("mis_cause", a_fc, 1);
        wdata = 32'(ED); tick(); we = 1'b0;
        chk("mis_hold", a_st, 3);
        chk("mis_hold_cause", a_fc, 1);

        // Timeout after exactly TOA run cycles.
        restart();
        repeat (TOA - 1) tick();
        chk("to_still_run", a_st, 1);
        tick();
        chk("to_state", a_st, 3);
        chk("to_cause", a_fc, 2);
        read_shadow(3'd4);
        chk("to_cycles", a_rd, TOA);

        // Saturation on the narrow instance.
        restart();
        ev = 4'b0010;
        repeat (20) tick();
        ev = '0;
        read_shadow(3'd1);
`ifdef TEST_MONITOR_EDGE_EN
        chk("sat_cnt", b_rd, 1);
        chk("sat_ovf", b_ovf[1], 0);
`else
        chk("sat_cnt", b_rd, 15);
        chk("sat_ovf", b_ovf[1], 1);
`endif

        // Matching write in the timeout cycle wins; clear beats start.
        restart();
        repeat (TOA - 1) tick();
        we = 1'b1; addr = 32'(CA); wdata = 32'(ED); tick(); we = 1'b0;
        chk("prio_pass", a_st, 2);
        clear = 1'b1; start = 1'b1; tick(); clear = 1'b0; start = 1'b0;
        chk("prio_idle", a_st, 0);
        read_shadow(3'd4);
        chk("prio_cycles0", a_rd, 0);
        rd_sel = 3'd0; tick();
        chk("prio_ev0", a_rd, 0);

        // Reset in the middle of a run.
        start = 1'b1; tick(); start = 1'b0;
        ev = 4'b0100; repeat (5) tick(); ev = '0;
        read_shadow(3'd2);
`ifdef TEST_MONITOR_EDGE_EN
        chk("mid_ev2", a_rd, 1);
`else
        chk("mid_ev2", a_rd, 5);
`endif
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        chk("mid_state", a_st, 0);
        chk("mid_done", a_done, 0);
        chk("mid_rd", a_rd, 0);
        chk("mid_ovf", a_ovf, 0);

        // Random traffic checked against the model every cycle.
        for (int n = 0; n < 600; n++) begin
            rst_n  = ($urandom_range(0, 149) != 0);
            clear  = ($urandom_range(0, 29) == 0);
            start  = ($urandom_range(0, 4) == 0);
            snap   = ($urandom_range(0, 4) == 0);
            rd_sel = 3'($urandom_range(0, 7));
            ev     = NE'($urandom);
            we     = ($urandom_range(0, 5) == 0);
            addr   = ($urandom_range(0, 1) == 0) ? 32'(CA) : 32'($urandom_range(370, 385));
            case ($urandom_range(0, 2))
                0:       wdata = 32'(ED);
                1:       wdata = 32'(ED) ^ (32'd1 << $urandom_range(0, 31));
                default: wdata = $urandom;
            endcase
            tick();
        end

        rst_n = 1'b1; clear = 1'b0; start = 1'b0; snap = 1'b0; we = 1'b0; ev = '0;
        tick();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
